// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundles every pipeline-facing signal of the hazard/control unit.
//   master : pipeline side. Drives the decode/execute/forwarding/redirect/halt/irq
//            inputs and receives the forwarded operands and the control strobes.
//   slave  : hazard_ctrl side, the mirror image of master.
// Signal groups:
//   dec_*          source indices and use flags of the instruction in DEC
//   ex_*           destination, load flag, source indices and D/X operand values in EX
//   fwd_*          per-stage forwarding candidates, packed with stage i at [i*W +: W]
//   br_taken, halt_req, irq
//                  redirect, halt and interrupt requests
//   ex_a_out, ex_b_out
//                  forwarded operands delivered to the ALU
//   stall_fd, bubble_dx, flush_fd, flush_dx, irq_ack, halted
//                  pipeline control strobes and status
interface hazard_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 3,
  parameter int NUM_FWD = 2
);
  logic [REG_AW-1:0]         dec_rs_a;
  logic [REG_AW-1:0]         dec_rs_b;
  logic                      dec_use_a;
  logic                      dec_use_b;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_mem_read;
  logic [REG_AW-1:0]         ex_rs_a;
  logic [REG_AW-1:0]         ex_rs_b;
  logic [DATA_W-1:0]         ex_a_in;
  logic [DATA_W-1:0]         ex_b_in;
  logic [NUM_FWD*REG_AW-1:0] fwd_rd;
  logic [NUM_FWD-1:0]        fwd_wr_en;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic                      br_taken;
  logic                      halt_req;
  logic                      irq;
  logic [DATA_W-1:0]         ex_a_out;
  logic [DATA_W-1:0]         ex_b_out;
  logic                      stall_fd;
  logic                      bubble_dx;
  logic                      flush_fd;
  logic                      flush_dx;
  logic                      irq_ack;
  logic                      halted;

  modport master (
    output dec_rs_a, dec_rs_b, dec_use_a, dec_use_b,
    output ex_rd, ex_mem_read, ex_rs_a, ex_rs_b, ex_a_in, ex_b_in,
    output fwd_rd, fwd_wr_en, fwd_valid, fwd_data,
    output br_taken, halt_req, irq,
    input  ex_a_out, ex_b_out,
    input  stall_fd, bubble_dx, flush_fd, flush_dx, irq_ack, halted
  );

  modport slave (
    input  dec_rs_a, dec_rs_b, dec_use_a, dec_use_b,
    input  ex_rd, ex_mem_read, ex_rs_a, ex_rs_b, ex_a_in, ex_b_in,
    input  fwd_rd, fwd_wr_en, fwd_valid, fwd_data,
    input  br_taken, halt_req, irq,
    output ex_a_out, ex_b_out,
    output stall_fd, bubble_dx, flush_fd, flush_dx, irq_ack, halted
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard and control unit for the 5-stage core. It handles the following:
//   - operand forwarding from NUM_FWD later stages into EX, where stage 0 is the nearest;
//   - load-use stalls that last LD_LAT cycles;
//   - F/D and D/X flushes on a branch or jump;
//   - interrupt entry on an edge, acknowledged with a one-cycle irq_ack;
//   - a halt drain of DRAIN_CYC cycles, followed by a sticky HALTED state.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : hazard_ctrl_if.slave (pipeline-facing signals, see the interface header)
// All control outputs are combinational decodes of the current state and inputs.
module hazard_ctrl #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 3,
  parameter int NUM_FWD   = 2,
  parameter int LD_LAT    = 1,
  parameter int DRAIN_CYC = 3
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, LDSTALL, DRAIN, HALTED} state_t;

  // The counter holds the number of further cycles left in LDSTALL/DRAIN after the current one.
  localparam logic [3:0] LD_CNT    = (LD_LAT > 1) ? 4'(LD_LAT - 2) : 4'd0;
  localparam logic [3:0] DRAIN_CNT = 4'(DRAIN_CYC - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] cnt;
  logic [3:0] next_cnt;
  logic       irq_sync;
  logic       irq_sync_q;
  logic       irq_pend;
  logic       load_use;
  logic       stall;
  logic       bubble;
  logic       fl_fd;
  logic       fl_dx;
  logic       ack;
  logic       halt_st;

  // Forwarding. The loop walks from the oldest stage to the nearest stage, so the
  // lowest-index match is written last and wins. A load result that is not yet
  // final is skipped.
  always_comb begin
    bus.ex_a_out = bus.ex_a_in;
    bus.ex_b_out = bus.ex_b_in;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (bus.fwd_wr_en[i] && bus.fwd_valid[i] &&
          bus.fwd_rd[i*REG_AW +: REG_AW] == bus.ex_rs_a)
        bus.ex_a_out = bus.fwd_data[i*DATA_W +: DATA_W];
      if (bus.fwd_wr_en[i] && bus.fwd_valid[i] &&
          bus.fwd_rd[i*REG_AW +: REG_AW] == bus.ex_rs_b)
        bus.ex_b_out = bus.fwd_data[i*DATA_W +: DATA_W];
    end
  end

  assign load_use = bus.ex_mem_read &
                    ((bus.dec_use_a & (bus.ex_rd == bus.dec_rs_a)) |
                     (bus.dec_use_b & (bus.ex_rd == bus.dec_rs_b)));

  // Control decode and next state. Only one event is honoured per cycle, in the
  // order halt, branch, load-use, interrupt.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stall      = 1'b0;
    bubble     = 1'b0;
    fl_fd      = 1'b0;
    fl_dx      = 1'b0;
    ack        = 1'b0;
    halt_st    = 1'b0;
    if (rst) begin
      fl_fd = 1'b1;
      fl_dx = 1'b1;
    end else begin
      case (state)
        RUN, LDSTALL: begin
          if (bus.halt_req) begin
            fl_fd      = 1'b1;
            fl_dx      = 1'b1;
            next_state = DRAIN;
            next_cnt   = DRAIN_CNT;
          end else if (bus.br_taken) begin
            fl_fd      = 1'b1;
            fl_dx      = 1'b1;
            next_state = RUN;
          end else if (state == LDSTALL) begin
            stall    = 1'b1;
            bubble   = 1'b1;
            next_cnt = cnt - 4'd1;
            if (cnt == 4'd0)
              next_state = RUN;
          end else if (load_use) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LD_LAT > 1) begin
              next_state = LDSTALL;
              next_cnt   = LD_CNT;
            end
          end else if (irq_pend) begin
            ack   = 1'b1;
            fl_fd = 1'b1;
          end
        end
        DRAIN: begin
          fl_fd    = 1'b1;
          fl_dx    = 1'b1;
          stall    = 1'b1;
          next_cnt = cnt - 4'd1;
          if (cnt == 4'd0)
            next_state = HALTED;
        end
        default: begin
          halt_st = 1'b1;
          stall   = 1'b1;
          fl_fd   = 1'b1;
          fl_dx   = 1'b1;
        end
      endcase
    end
  end

  assign bus.stall_fd  = stall;
  assign bus.bubble_dx = bubble;
  assign bus.flush_fd  = fl_fd;
  assign bus.flush_dx  = fl_dx;
  assign bus.irq_ack   = ack;
  assign bus.halted    = halt_st;

  // State register and interrupt edge capture. An edge is taken from irq_sync
  // rising, and it is dropped once the core has begun to drain. A new edge that
  // arrives in the same cycle as an ack leaves the interrupt pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= 4'd0;
      irq_sync   <= 1'b0;
      irq_sync_q <= 1'b0;
      irq_pend   <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      irq_sync   <= bus.irq;
      irq_sync_q <= irq_sync;
      irq_pend   <= (irq_sync & ~irq_sync_q & ((state == RUN) | (state == LDSTALL))) |
                    (irq_pend & ~ack);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Two instances of hazard_ctrl, one with LD_LAT=1 and one with LD_LAT=4, receive
// the same stimulus. For each cycle the driver computes the expected outputs of
// each instance from a reference model and pushes them into a per-instance queue.
// The monitor takes those entries off the queues on the falling edge and compares
// them against the instance outputs.
module tb_hazard_ctrl;
  localparam int DW   = 32;
  localparam int AW   = 3;
  localparam int NF   = 2;
  localparam int DC   = 3;
  localparam int LDL0 = 1;
  localparam int LDL1 = 4;

  localparam int M_RUN   = 0;
  localparam int M_STALL = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;

  typedef struct {
    logic          rst;
    logic [AW-1:0] dec_rs_a, dec_rs_b, ex_rd, ex_rs_a, ex_rs_b;
    logic          dec_use_a, dec_use_b, ex_mem_read, br_taken, halt_req, irq;
    logic [DW-1:0] ex_a_in, ex_b_in;
    logic [NF*AW-1:0] fwd_rd;
    logic [NF-1:0]    fwd_wr_en, fwd_valid;
    logic [NF*DW-1:0] fwd_data;
  } stim_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [5:0]    ctl;
  } exp_t;

  // The model tracks the number of stall or drain cycles left, counting the current one.
  typedef struct {
    int mode;
    int left;
    bit h1;
    bit h2;
    bit pend;
  } model_t;

  logic  clk = 1'b0;
  logic  rst;
  stim_t cur;
  int    tests_run = 0;
  int    tests_failed = 0;

  logic [DW-1:0] act_a [2];
  logic [DW-1:0] act_b [2];
  logic [5:0]    act_ctl [2];

  exp_t   q0[$];
  exp_t   q1[$];
  model_t m0, m1;

  always #5 clk = ~clk;

  assign rst = cur.rst;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_ctrl_if #(.DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF)) bus ();

    assign bus.dec_rs_a    = cur.dec_rs_a;
    assign bus.dec_rs_b    = cur.dec_rs_b;
    assign bus.dec_use_a   = cur.dec_use_a;
    assign bus.dec_use_b   = cur.dec_use_b;
    assign bus.ex_rd       = cur.ex_rd;
    assign bus.ex_mem_read = cur.ex_mem_read;
    assign bus.ex_rs_a     = cur.ex_rs_a;
    assign bus.ex_rs_b     = cur.ex_rs_b;
    assign bus.ex_a_in     = cur.ex_a_in;
    assign bus.ex_b_in     = cur.ex_b_in;
    assign bus.fwd_rd      = cur.fwd_rd;
    assign bus.fwd_wr_en   = cur.fwd_wr_en;
    assign bus.fwd_valid   = cur.fwd_valid;
    assign bus.fwd_data    = cur.fwd_data;
    assign bus.br_taken    = cur.br_taken;
    assign bus.halt_req    = cur.halt_req;
    assign bus.irq         = cur.irq;

    assign act_a[g]   = bus.ex_a_out;
    assign act_b[g]   = bus.ex_b_out;
    assign act_ctl[g] = {bus.stall_fd, bus.bubble_dx, bus.flush_fd,
                         bus.flush_dx, bus.irq_ack, bus.halted};

    hazard_ctrl #(
      .DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF),
      .LD_LAT((g == 0) ? LDL0 : LDL1), .DRAIN_CYC(DC)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  // Returns the result of the first stage, in age order, that holds a final write to reg; otherwise dflt.
  function automatic logic [DW-1:0] fwdPick(input stim_t s, input logic [AW-1:0] rg,
                                            input logic [DW-1:0] dflt);
    for (int i = 0; i < NF; i++)
      if (s.fwd_wr_en[i] && s.fwd_valid[i] && s.fwd_rd[i*AW +: AW] == rg)
        return s.fwd_data[i*DW +: DW];
    return dflt;
  endfunction

  task automatic modelStep(input stim_t s, input int ld_lat, input model_t m,
                           output model_t n, output exp_t e);
    bit hazard, ack, stall, bubble, ffd, fdx, hlt;
    n = m;
    ack = 0; stall = 0; bubble = 0; ffd = 0; fdx = 0; hlt = 0;
    e.a = fwdPick(s, s.ex_rs_a, s.ex_a_in);
    e.b = fwdPick(s, s.ex_rs_b, s.ex_b_in);
    hazard = s.ex_mem_read && ((s.dec_use_a && s.ex_rd == s.dec_rs_a) ||
                               (s.dec_use_b && s.ex_rd == s.dec_rs_b));
    if (s.rst) begin
      ffd = 1; fdx = 1;
      n.mode = M_RUN; n.left = 0; n.h1 = 0; n.h2 = 0; n.pend = 0;
    end else begin
      if ((m.mode == M_RUN || m.mode == M_STALL) && s.halt_req) begin
        ffd = 1; fdx = 1; n.mode = M_DRAIN; n.left = DC;
      end else if ((m.mode == M_RUN || m.mode == M_STALL) && s.br_taken) begin
        ffd = 1; fdx = 1; n.mode = M_RUN;
      end else if (m.mode == M_STALL) begin
        stall = 1; bubble = 1; n.left = m.left - 1;
        if (n.left == 0) n.mode = M_RUN;
      end else if (m.mode == M_RUN) begin
        if (hazard) begin
          stall = 1; bubble = 1;
          if (ld_lat > 1) begin n.mode = M_STALL; n.left = ld_lat - 1; end
        end else if (m.pend) begin
          ack = 1; ffd = 1;
        end
      end else if (m.mode == M_DRAIN) begin
        ffd = 1; fdx = 1; stall = 1; n.left = m.left - 1;
        if (n.left == 0) n.mode = M_HALT;
      end else begin
        hlt = 1; stall = 1; ffd = 1; fdx = 1;
      end
      n.pend = (m.h1 && !m.h2 && (m.mode == M_RUN || m.mode == M_STALL)) || (m.pend && !ack);
      n.h2 = m.h1;
      n.h1 = s.irq;
    end
    e.ctl = {stall, bubble, ffd, fdx, ack, hlt};
  endtask

  task automatic checkOutput(input string nm, input logic [DW-1:0] aa, input logic [DW-1:0] ab,
                             input logic [5:0] ac, input exp_t e);
    tests_run++;
    if (aa !== e.a) begin
      tests_failed++;
      $display("[TB] FAIL %s ex_a_out got %h want %h at %0t", nm, aa, e.a, $time);
    end
    tests_run++;
    if (ab !== e.b) begin
      tests_failed++;
      $display("[TB] FAIL %s ex_b_out got %h want %h at %0t", nm, ab, e.b, $time);
    end
    tests_run++;
    if (ac !== e.ctl) begin
      tests_failed++;
      $display("[TB] FAIL %s ctl{stall,bubble,ffd,fdx,ack,halted} got %b want %b at %0t",
               nm, ac, e.ctl, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t   e;
    model_t n;
    @(posedge clk);
    #1;
    cur = s;
    modelStep(s, LDL0, m0, n, e); m0 = n; q0.push_back(e);
    modelStep(s, LDL1, m1, n, e); m1 = n; q1.push_back(e);
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rst         = ($urandom_range(99) < 3);
    s.dec_rs_a    = AW'($urandom());
    s.dec_rs_b    = AW'($urandom());
    s.dec_use_a   = 1'($urandom());
    s.dec_use_b   = 1'($urandom());
    s.ex_rd       = AW'($urandom());
    s.ex_mem_read = ($urandom_range(99) < 40);
    s.ex_rs_a     = AW'($urandom());
    s.ex_rs_b     = AW'($urandom());
    s.ex_a_in     = $urandom();
    s.ex_b_in     = $urandom();
    s.fwd_rd      = (NF*AW)'($urandom());
    s.fwd_wr_en   = NF'($urandom());
    s.fwd_valid   = NF'($urandom());
    s.fwd_data    = {$urandom(), $urandom()};
    s.br_taken    = ($urandom_range(99) < 12);
    s.halt_req    = ($urandom_range(99) < 2);
    s.irq         = cur.irq ^ ($urandom_range(99) < 15);
    return s;
  endfunction

  // Monitor: one queue entry per instance is checked on each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checkOutput("ld1", act_a[0], act_b[0], act_ctl[0], e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checkOutput("ld4", act_a[1], act_b[1], act_ctl[1], e);
    end
  end

  initial begin
    stim_t s;
    m0 = '{M_RUN, 0, 0, 0, 0};
    m1 = '{M_RUN, 0, 0, 0, 0};
    s = idleStim();
    s.rst = 1;
    cur = s;
    repeat (2) applyStimulus(s);
    s.rst = 0;
    applyStimulus(s);

    // Two stages write r5; the nearest one wins, then the older one, then an unfinished load is skipped.
    s.fwd_rd = {3'd5, 3'd5}; s.fwd_wr_en = 2'b11; s.fwd_valid = 2'b11;
    s.fwd_data = {32'h0000BBBB, 32'h0000AAAA}; s.ex_rs_a = 3'd5;
    s.ex_a_in = 32'h12345678; s.ex_b_in = 32'h9ABCDEF0;
    applyStimulus(s);
    s.fwd_wr_en = 2'b10;
    applyStimulus(s);
    s.fwd_wr_en = 2'b11; s.fwd_valid = 2'b10;
    applyStimulus(s);

    // Load to r3 in EX while DEC reads r3 as source B, followed by the result forwarding from MEM.
    s = idleStim();
    s.ex_mem_read = 1; s.ex_rd = 3'd3; s.dec_rs_b = 3'd3; s.dec_use_b = 1;
    applyStimulus(s);
    s = idleStim();
    s.ex_rs_b = 3'd3; s.fwd_rd = {3'd0, 3'd3}; s.fwd_wr_en = 2'b01; s.fwd_valid = 2'b01;
    s.fwd_data = {32'h0, 32'hC0FFEE00};
    applyStimulus(s);
    s = idleStim();
    repeat (4) applyStimulus(s);

    // A branch and a load-use hazard in the same cycle.
    s.ex_mem_read = 1; s.ex_rd = 3'd2; s.dec_rs_a = 3'd2; s.dec_use_a = 1; s.br_taken = 1;
    applyStimulus(s);
    s = idleStim();
    applyStimulus(s);

    // irq held high, then dropped and raised again.
    s.irq = 1; repeat (10) applyStimulus(s);
    s.irq = 0; repeat (3) applyStimulus(s);
    s.irq = 1; repeat (5) applyStimulus(s);
    s.irq = 0; applyStimulus(s);

    // An irq edge during a long load stall, followed by reset while still stalled.
    s = idleStim();
    s.irq = 1; s.ex_mem_read = 1; s.ex_rd = 3'd6; s.dec_rs_a = 3'd6; s.dec_use_a = 1;
    repeat (3) applyStimulus(s);
    s.rst = 1; applyStimulus(s);
    s = idleStim(); s.irq = 1;
    repeat (4) applyStimulus(s);

    // Halt: drain, then the sticky halted state that ignores branches and interrupts, then reset.
    s = idleStim(); s.halt_req = 1; applyStimulus(s);
    s.halt_req = 0; s.br_taken = 1;
    for (int i = 0; i < 6; i++) begin
      s.irq = i[0];
      applyStimulus(s);
    end
    s = idleStim(); s.rst = 1; applyStimulus(s);
    s.rst = 0; applyStimulus(s);

    repeat (2000) applyStimulus(randStim());

    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL queue_drain left %0d/%0d want 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
